// File: rtl/sect283k1_scalar_load.sv
// sect283k1 scalar loader: assembles nine 32-bit words into a 288-bit
// scalar, checks framing, range (< 2^283) and optionally all-zero, then hands
// the 283-bit scalar to the point multiplier and waits for its completion.
module sect283k1_scalar_load #(
  parameter bit EnZeroChk = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  output logic         pm_start,
  output logic [282:0] pm_d,
  input  logic         pm_done,
  output logic         busy,
  output logic         err,
  output logic [1:0]   err_code,
  output logic         ack
);

  typedef enum logic [2:0] {LOAD, CHECK, ISSUE, WAIT, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [3:0]     cnt;
  logic [287:0]   asm_reg;
  logic           done_q;

  logic           xfer;
  logic           range_bad;
  logic           zero_bad;
  logic           done_rise;

  logic           asm_load, asm_clr, cnt_inc, cnt_clr;
  logic           busy_set, busy_clr, err_set, issue, ack_set;
  logic [1:0]     err_code_set;

  assign s_ready   = (state == LOAD) || (state == DRAIN);
  assign xfer      = s_valid && s_ready;
  assign range_bad = |asm_reg[287:283];
  assign zero_bad  = EnZeroChk && (asm_reg == '0);
  assign done_rise = pm_done && !done_q;

  // State register; clr behaves like a one-cycle synchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= LOAD;
    else if (clr) state <= LOAD;
    else          state <= state_nxt;
  end

  // Next-state and per-cycle control strobes for the datapath.
  always_comb begin
    state_nxt    = state;
    asm_load     = 1'b0;
    asm_clr      = 1'b0;
    cnt_inc      = 1'b0;
    cnt_clr      = 1'b0;
    busy_set     = 1'b0;
    busy_clr     = 1'b0;
    err_set      = 1'b0;
    err_code_set = 2'b00;
    issue        = 1'b0;
    ack_set      = 1'b0;
    case (state)
      LOAD: begin
        if (xfer) begin
          if (cnt == 4'd8) begin
            if (s_last) begin
              asm_load  = 1'b1;
              busy_set  = 1'b1;
              state_nxt = CHECK;
            end else begin
              err_set      = 1'b1;
              err_code_set = 2'b11;
              asm_clr      = 1'b1;
              cnt_clr      = 1'b1;
              busy_clr     = 1'b1;
              state_nxt    = DRAIN;
            end
          end else if (s_last) begin
            err_set      = 1'b1;
            err_code_set = 2'b11;
            asm_clr      = 1'b1;
            cnt_clr      = 1'b1;
            busy_clr     = 1'b1;
          end else begin
            asm_load = 1'b1;
            cnt_inc  = 1'b1;
            busy_set = 1'b1;
          end
        end
      end
      CHECK: begin
        if (range_bad || zero_bad) begin
          err_set      = 1'b1;
          err_code_set = range_bad ? 2'b10 : 2'b01;
          asm_clr      = 1'b1;
          cnt_clr      = 1'b1;
          busy_clr     = 1'b1;
          state_nxt    = LOAD;
        end else begin
          issue     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (done_rise) begin
          ack_set   = 1'b1;
          busy_clr  = 1'b1;
          cnt_clr   = 1'b1;
          asm_clr   = 1'b1;
          state_nxt = LOAD;
        end
      end
      DRAIN: begin
        if (xfer && s_last) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Datapath and registered outputs: assembly, counter, pulses and scalar.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      asm_reg  <= '0;
      done_q   <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
      ack      <= 1'b0;
      pm_start <= 1'b0;
      pm_d     <= '0;
    end else if (clr) begin
      cnt      <= '0;
      asm_reg  <= '0;
      done_q   <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
      ack      <= 1'b0;
      pm_start <= 1'b0;
      pm_d     <= '0;
    end else begin
      done_q   <= pm_done;
      err      <= err_set;
      ack      <= ack_set;
      pm_start <= issue;
      if (err_set)       err_code <= err_code_set;
      if (busy_clr)      busy <= 1'b0;
      else if (busy_set) busy <= 1'b1;
      if (cnt_clr)       cnt <= '0;
      else if (cnt_inc)  cnt <= cnt + 4'd1;
      if (asm_clr)       asm_reg <= '0;
      else if (asm_load) asm_reg[{cnt, 5'd0} +: 32] <= s_data;
      if (issue)         pm_d <= asm_reg[282:0];
    end
  end

endmodule

// File: tb/tb_sect283k1_scalar_load.sv
// Self-checking bench for sect283k1_scalar_load: directed and random scalars
// compared against a word-packing reference model of the scalar rules.
module tb_sect283k1_scalar_load;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         s_valid = 1'b0;
  logic [31:0]  s_data = '0;
  logic         s_last = 1'b0;
  logic         pm_done = 1'b0;

  logic         s_ready, pm_start, busy, err, ack;
  logic [282:0] pm_d;
  logic [1:0]   err_code;

  logic         s_ready_nz, pm_start_nz, busy_nz, err_nz, ack_nz;
  logic [282:0] pm_d_nz;
  logic [1:0]   err_code_nz;

  int checks = 0;
  int failures = 0;
  int pmStartCnt = 0;
  int pmStartNzCnt = 0;
  int errCnt = 0;
  int ackCnt = 0;
  int mutexViol = 0;

  logic [31:0] words [9];

  sect283k1_scalar_load dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .pm_start(pm_start), .pm_d(pm_d), .pm_done(pm_done),
    .busy(busy), .err(err), .err_code(err_code), .ack(ack)
  );

  sect283k1_scalar_load #(.EnZeroChk(1'b0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .s_valid(s_valid), .s_ready(s_ready_nz), .s_data(s_data), .s_last(s_last),
    .pm_start(pm_start_nz), .pm_d(pm_d_nz), .pm_done(pm_done),
    .busy(busy_nz), .err(err_nz), .err_code(err_code_nz), .ack(ack_nz)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (pm_start)    pmStartCnt++;
    if (pm_start_nz) pmStartNzCnt++;
    if (err)         errCnt++;
    if (ack)         ackCnt++;
    if ((int'(pm_start) + int'(err) + int'(ack)) > 1) mutexViol++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Word 0 is least significant; returns the full 288-bit value.
  function automatic logic [287:0] packScalar();
    logic [287:0] r = '0;
    for (int i = 0; i < 9; i++) r = r | (288'(words[i]) << (32 * i));
    return r;
  endfunction

  // 0 = accepted, 2 = out of range (>= 2^283), 1 = zero when checked.
  function automatic int expectCode(input bit zeroChk);
    logic [287:0] r = packScalar();
    if (r >= (288'd1 << 283)) return 2;
    if (zeroChk && r == 0) return 1;
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Offers one word and returns one cycle after it has been taken.
  task automatic applyStimulus(input logic [31:0] d, input logic last);
    int guard = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!s_ready) checkOutput("s_ready_timeout", s_ready, 1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic sendScalar(input bit gaps);
    for (int i = 0; i < 9; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      applyStimulus(words[i], logic'(i == 8));
    end
  endtask

  task automatic finishJob(input string tag, input int delay);
    int a0 = ackCnt;
    int guard = 0;
    idle(delay);
    pm_done = 1'b1;
    while (ackCnt == a0 && guard < 10) begin
      tick();
      guard++;
    end
    idle(3);
    checkOutput($sformatf("%s_ack_once", tag), ackCnt - a0, 1);
    checkOutput($sformatf("%s_busy_low", tag), busy, 0);
    pm_done = 1'b0;
    tick();
  endtask

  task automatic runGood(input string tag, input int delay, input bit gaps);
    logic [287:0] full = packScalar();
    int p0 = pmStartCnt;
    sendScalar(gaps);
    checkOutput($sformatf("%s_no_start_T1", tag), pm_start, 0);
    tick();
    checkOutput($sformatf("%s_start_T2", tag), pm_start, 1);
    checkOutput($sformatf("%s_pm_d", tag), pm_d, full[282:0]);
    checkOutput($sformatf("%s_pm_d_nz", tag), pm_d_nz, full[282:0]);
    checkOutput($sformatf("%s_busy", tag), busy, 1);
    tick();
    checkOutput($sformatf("%s_start_once", tag), pmStartCnt - p0, 1);
    finishJob(tag, delay);
    checkOutput($sformatf("%s_pm_d_held", tag), pm_d, full[282:0]);
  endtask

  task automatic runBad(input string tag, input int code);
    int e0 = errCnt;
    int p0 = pmStartCnt;
    sendScalar(1'b0);
    idle(3);
    checkOutput($sformatf("%s_err_once", tag), errCnt - e0, 1);
    checkOutput($sformatf("%s_err_code", tag), err_code, code);
    checkOutput($sformatf("%s_no_start", tag), pmStartCnt - p0, 0);
    checkOutput($sformatf("%s_busy_low", tag), busy, 0);
  endtask

  task automatic runAuto(input string tag, input bit gaps);
    int code = expectCode(1'b1);
    if (code == 0) runGood(tag, $urandom_range(1, 8), gaps);
    else runBad(tag, code);
  endtask

  initial begin
    int e0, a0, p0, pn0;

    // Reset values while rst_n is held low.
    #12;
    checkOutput("rst_pm_start", pm_start, 0);
    checkOutput("rst_pm_d", pm_d, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_err_code", err_code, 0);
    checkOutput("rst_ack", ack, 0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("rst_s_ready", s_ready, 1);

    // Scalar of value 1, completion raised 20 cycles after issue.
    words[0] = 32'h1;
    for (int i = 1; i < 9; i++) words[i] = 32'h0;
    runGood("one", 20, 1'b0);

    // Range boundaries: top word bit 31 is scalar bit 287, bit 27 is bit 283.
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    words[8] = 32'h8000_0000;
    runBad("range_b287", 2);
    words[8] = 32'h0800_0000;
    runBad("range_b283", 2);
    for (int i = 0; i < 9; i++) words[i] = 32'hFFFF_FFFF;
    words[8] = 32'h07FF_FFFF;
    runGood("range_max", 4, 1'b0);

    // All-zero scalar: rejected when checked, issued when the check is off.
    for (int i = 0; i < 9; i++) words[i] = 32'h0;
    e0 = errCnt; p0 = pmStartCnt; pn0 = pmStartNzCnt;
    sendScalar(1'b0);
    idle(3);
    checkOutput("zero_err_once", errCnt - e0, 1);
    checkOutput("zero_err_code", err_code, 1);
    checkOutput("zero_no_start", pmStartCnt - p0, 0);
    checkOutput("zero_nz_start", pmStartNzCnt - pn0, 1);
    checkOutput("zero_nz_pm_d", pm_d_nz, 0);
    checkOutput("zero_nz_busy", busy_nz, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checkOutput("zero_nz_clr_busy", busy_nz, 0);

    // Early s_last on the fourth word, then a 0x55.. scalar.
    e0 = errCnt;
    for (int i = 0; i < 3; i++) applyStimulus($urandom, 1'b0);
    applyStimulus($urandom, 1'b1);
    idle(2);
    checkOutput("short_err_once", errCnt - e0, 1);
    checkOutput("short_err_code", err_code, 3);
    checkOutput("short_busy_low", busy, 0);
    for (int i = 0; i < 8; i++) words[i] = 32'h5555_5555;
    words[8] = 32'h0555_5555;
    runGood("fives", 5, 1'b0);

    // Twelve words with s_last only on the last: drained, then a new scalar.
    e0 = errCnt;
    for (int i = 0; i < 12; i++) applyStimulus($urandom, logic'(i == 11));
    idle(2);
    checkOutput("long_err_once", errCnt - e0, 1);
    checkOutput("long_err_code", err_code, 3);
    checkOutput("long_ready", s_ready, 1);
    for (int i = 0; i < 9; i++) words[i] = $urandom;
    words[8] = words[8] & 32'h07FF_FFFF;
    runGood("after_drain", 3, 1'b1);

    // clr while waiting for the multiplier: the later done edge gives no ack.
    for (int i = 0; i < 9; i++) words[i] = $urandom | 32'h1;
    words[8] = words[8] & 32'h07FF_FFFF;
    sendScalar(1'b0);
    tick();
    checkOutput("clrw_start", pm_start, 1);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checkOutput("clrw_busy", busy, 0);
    checkOutput("clrw_pm_d", pm_d, 0);
    checkOutput("clrw_err_code", err_code, 0);
    a0 = ackCnt;
    pm_done = 1'b1;
    idle(5);
    checkOutput("clrw_no_ack", ackCnt - a0, 0);
    pm_done = 1'b0;
    tick();

    // Random scalars with random valid gaps.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 9; i++) words[i] = $urandom;
      if ($urandom_range(0, 2) != 0) words[8] = words[8] & 32'h07FF_FFFF;
      runAuto($sformatf("rand%0d", k), 1'b1);
    end

    // Reset with five words loaded, then a clean scalar.
    for (int i = 0; i < 5; i++) applyStimulus(32'hFFFF_FFFF, 1'b0);
    checkOutput("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #2;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_pm_d", pm_d, 0);
    checkOutput("mid_rst_err_code", err_code, 0);
    checkOutput("mid_rst_start", pm_start, 0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("mid_rst_ready", s_ready, 1);
    for (int i = 0; i < 9; i++) words[i] = 32'h0;
    words[0] = 32'h0000_1234;
    words[5] = 32'h0000_000A;
    runGood("post_rst", 2, 1'b0);

    checkOutput("pulse_exclusive", mutexViol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
